spike_window_classifier: RTL and testbench
==========================================

SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter N_NEURONS, default 8: number of LIF spike_out lines observed.
REQ-003 Parameter CNT_W, default 8: width of each per-neuron spike counter.
REQ-004 clk  input  1  rising-edge clock shared with the LIF array.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to open a counting window; honoured only in IDLE.
REQ-007 window_len  input  8  number of timesteps per window; sampled on the accepted start.
REQ-008 spike_valid  input  1  strobe marking one LIF timestep; spike_in valid when high.
REQ-009 spike_in  input  N_NEURONS  spike_out bits of the LIF neurons, bit i = neuron i.
REQ-010 result_ready  input  1  consumer accepts the result.
REQ-011 busy  output  1  high in COUNT, COMPARE and DONE.
REQ-012 result_valid  output  1  high only in DONE.
REQ-013 result_class  output  clog2(N_NEURONS)  index of the neuron with the highest count.
REQ-014 result_count  output  CNT_W  spike count of result_class.
REQ-015 result_tie  output  1  two or more neurons share the maximum count.
REQ-016 overrun  output  1  sticky: spike_valid arrived outside COUNT.

Function
REQ-017 FSM states SHALL be IDLE, COUNT, COMPARE, DONE.
REQ-018 IDLE: start=1 with window_len!=0 -> clear all counters and step counter, latch window_len, go COUNT next edge; start with window_len==0 ignored, stay IDLE.
REQ-019 COUNT: each edge with spike_valid=1 -> cnt[i] += spike_in[i] for all i, step counter +1; spike_valid=0 -> no change.
REQ-020 Counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-021 When the accepted spike_valid is timestep number window_len, the same edge SHALL move to COMPARE with scan index 0.
REQ-022 COMPARE: one neuron per cycle, index 0..N_NEURONS-1; index 0 loads best_cnt=cnt[0], best_idx=0, tie=0 unconditionally.
REQ-023 COMPARE, index>0: cnt[idx]>best_cnt -> update best, tie=0; cnt[idx]==best_cnt -> tie=1, best unchanged (lowest index wins); less -> no change.
REQ-024 Edge processing index N_NEURONS-1 SHALL enter DONE; result_valid high exactly N_NEURONS edges after the edge sampling the final timestep.
REQ-025 All-zero counts SHALL yield result_class=0, result_count=0, result_tie=1.
REQ-026 DONE: result_* held stable while result_valid=1 and result_ready=0; result_ready=1 -> IDLE next edge, result_valid low.
REQ-027 start while busy SHALL be ignored, including start coincident with the result_ready handshake.
REQ-028 spike_valid in IDLE, COMPARE or DONE SHALL be dropped and SHALL set overrun; overrun clears only on reset or an accepted start.
REQ-029 Changes to window_len after an accepted start SHALL not affect the current window.

Reset
REQ-030 reset=1 SHALL, on the next edge, force IDLE from any state, abandoning a window mid-count or mid-compare.
REQ-031 Reset values: busy=0, result_valid=0, result_class=0, result_count=0, result_tie=0, overrun=0, all counters 0.
REQ-032 reset SHALL take priority over start, spike_valid and result_ready in the same cycle.

Verification
REQ-033 window_len=4, neuron 3 spikes in all 4 steps, neuron 5 in 2 -> result_class=3, result_count=4, tie=0, result_valid 8 edges after step 4.
REQ-034 window_len=3, neurons 1 and 6 each spike 3 times -> result_class=1, result_count=3, tie=1.
REQ-035 window_len=255 (CNT_W=8... set CNT_W=4), neuron 0 spikes every step -> result_count=15 (saturated), class 0.
REQ-036 result_ready held 0 for 10 cycles in DONE -> outputs stable; start pulses ignored; spike_valid pulses set overrun; result_ready=1 -> IDLE next edge.
REQ-037 reset asserted in COUNT after 2 of 5 steps -> IDLE, all outputs 0; new start with window_len=1 and spike_in=8'h80 -> class 7, count 1.
REQ-038 start with window_len=0 -> busy stays 0, no result produced.

Source files
------------

// File: rtl/spike_window_classifier.sv
// Counts LIF spikes per neuron over a window of timesteps, then scans the
// counters one neuron per cycle to report the winner, its count and any tie.
module spike_window_classifier #(
    parameter  int N_NEURONS = 8,
    parameter  int CNT_W     = 8,
    localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           window_len,
    input  logic                 spike_valid,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 result_valid,
    output logic [IDX_W-1:0]     result_class,
    output logic [CNT_W-1:0]     result_count,
    output logic                 result_tie,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, COUNT, COMPARE, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt [N_NEURONS];
    logic [7:0]       step;
    logic [7:0]       win_len;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
    logic             tie;
    logic             start_ok;
    logic             last_step;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        start_ok     = (state == IDLE) && start && (window_len != 8'd0);
        last_step    = (state == COUNT) && spike_valid && (step == win_len - 8'd1);
        busy         = (state != IDLE);
        result_valid = (state == DONE);
        case (state)
            IDLE:    if (start_ok) next_state = COUNT;
            COUNT:   if (last_step) next_state = COMPARE;
            COMPARE: if (scan_idx == LAST_IDX) next_state = DONE;
            DONE:    if (result_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counting and the serial max-scan; the scan keeps the lowest index on equality.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) cnt[i] <= '0;
            step     <= '0;
            win_len  <= '0;
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
            tie      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (start_ok) begin
                for (int i = 0; i < N_NEURONS; i++) cnt[i] <= '0;
                step     <= '0;
                win_len  <= window_len;
                scan_idx <= '0;
                overrun  <= 1'b0;
            end
            if (spike_valid && (state != COUNT)) overrun <= 1'b1;

            if ((state == COUNT) && spike_valid) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    if (spike_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
                end
                step <= step + 8'd1;
                if (last_step) scan_idx <= '0;
            end

            if (state == COMPARE) begin
                if (scan_idx == '0) begin
                    best_cnt <= cnt[0];
                    best_idx <= '0;
                    tie      <= 1'b0;
                end else if (cnt[scan_idx] > best_cnt) begin
                    best_cnt <= cnt[scan_idx];
                    best_idx <= scan_idx;
                    tie      <= 1'b0;
                end else if (cnt[scan_idx] == best_cnt) begin
                    tie <= 1'b1;
                end
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end
    end

    assign result_class = best_idx;
    assign result_count = best_cnt;
    assign result_tie   = tie;

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed bench for spike_window_classifier: a default instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation case.
module tb_spike_window_classifier;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] window_len;
    logic       spike_valid;
    logic [7:0] spike_in;
    logic       result_ready;

    logic       busy, result_valid, result_tie, overrun;
    logic [2:0] result_class;
    logic [7:0] result_count;

    logic       busy_4, result_valid_4, result_tie_4, overrun_4;
    logic [2:0] result_class_4;
    logic [3:0] result_count_4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_window_classifier dut (
        .clk(clk), .reset(reset), .start(start), .window_len(window_len),
        .spike_valid(spike_valid), .spike_in(spike_in), .result_ready(result_ready),
        .busy(busy), .result_valid(result_valid), .result_class(result_class),
        .result_count(result_count), .result_tie(result_tie), .overrun(overrun)
    );

    spike_window_classifier #(.N_NEURONS(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .window_len(window_len),
        .spike_valid(spike_valid), .spike_in(spike_in), .result_ready(result_ready),
        .busy(busy_4), .result_valid(result_valid_4), .result_class(result_class_4),
        .result_count(result_count_4), .result_tie(result_tie_4), .overrun(overrun_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_window(input logic [7:0] len);
        start      = 1'b1;
        window_len = len;
        tick();
        start      = 1'b0;
        window_len = 8'hAA;
    endtask

    task automatic wait_valid(output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (result_valid) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1; window_len = 8'd3; spike_valid = 1'b1; spike_in = 8'hFF; result_ready = 1'b1;
        tick(); tick();
        start = 1'b0; spike_valid = 1'b0; spike_in = 8'h00; result_ready = 1'b0;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, result_valid, result_class, result_count, result_tie, overrun} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got busy=%0b valid=%0b class=%0d count=%0d tie=%0b ovr=%0b want all 0",
                     busy, result_valid, result_class, result_count, result_tie, overrun);
        end
        checks++;
        if ({busy_4, result_valid_4, result_count_4} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_cnt4 got busy=%0b valid=%0b count=%0d want 0",
                     busy_4, result_valid_4, result_count_4);
        end
    endtask

    task automatic test_basic();
        logic [7:0] pattern [4] = '{8'h28, 8'h28, 8'h08, 8'h08};
        open_window(8'd4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_busy got %0b want 1", busy);
        end
        for (int s = 0; s < 4; s++) begin
            if (s == 2) begin
                spike_valid = 1'b0; spike_in = 8'hFF;
                tick();
            end
            spike_valid = 1'b1;
            spike_in    = pattern[s];
            tick();
        end
        spike_valid = 1'b0; spike_in = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) begin
                checks++;
                if (result_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL basic_early_valid got %0b want 0 after 7 edges", result_valid);
                end
            end
        end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_latency got valid=%0b want 1 after 8 edges", result_valid);
        end
        checks++;
        if ({result_class, result_count, result_tie} !== {3'd3, 8'd4, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_result got class=%0d count=%0d tie=%0b want 3/4/0",
                     result_class, result_count, result_tie);
        end
        release_result();
        checks++;
        if ({busy, result_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL basic_release got busy=%0b valid=%0b want 0/0", busy, result_valid);
        end
    endtask

    task automatic test_tie();
        bit to;
        open_window(8'd3);
        for (int s = 0; s < 3; s++) begin
            spike_valid = 1'b1; spike_in = 8'h42;
            tick();
        end
        spike_valid = 1'b0; spike_in = 8'h00;
        wait_valid(to);
        checks++;
        if (to || {result_class, result_count, result_tie} !== {3'd1, 8'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL tie_result got timeout=%0b class=%0d count=%0d tie=%0b want 1/3/1",
                     to, result_class, result_count, result_tie);
        end
        release_result();
    endtask

    task automatic test_all_zero();
        bit to;
        open_window(8'd2);
        for (int s = 0; s < 2; s++) begin
            spike_valid = 1'b1; spike_in = 8'h00;
            tick();
        end
        spike_valid = 1'b0;
        wait_valid(to);
        checks++;
        if (to || {result_class, result_count, result_tie} !== {3'd0, 8'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zero_result got timeout=%0b class=%0d count=%0d tie=%0b want 0/0/1",
                     to, result_class, result_count, result_tie);
        end
        release_result();
    endtask

    task automatic test_saturate();
        bit to;
        open_window(8'd255);
        for (int s = 0; s < 255; s++) begin
            spike_valid = 1'b1; spike_in = 8'h01;
            tick();
        end
        spike_valid = 1'b0; spike_in = 8'h00;
        wait_valid(to);
        checks++;
        if (to || result_valid_4 !== 1'b1 || {result_class_4, result_count_4, result_tie_4} !== {3'd0, 4'd15, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sat_cnt4 got valid=%0b class=%0d count=%0d tie=%0b want 1/0/15/0",
                     result_valid_4, result_class_4, result_count_4, result_tie_4);
        end
        checks++;
        if (to || {result_class, result_count, result_tie} !== {3'd0, 8'd255, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sat_cnt8 got class=%0d count=%0d tie=%0b want 0/255/0",
                     result_class, result_count, result_tie);
        end
        release_result();
    endtask

    task automatic test_hold();
        bit to;
        int bad = 0;
        open_window(8'd1);
        spike_valid = 1'b1; spike_in = 8'h20;
        tick();
        spike_valid = 1'b0; spike_in = 8'h00;
        wait_valid(to);
        checks++;
        if (to || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_enter got timeout=%0b overrun=%0b want 0/0", to, overrun);
        end
        for (int c = 0; c < 10; c++) begin
            start       = (c % 2 == 0);
            window_len  = 8'd3;
            spike_valid = (c == 3);
            spike_in    = 8'hFF;
            tick();
            if ({result_valid, busy, result_class, result_count, result_tie} !== {1'b1, 1'b1, 3'd5, 8'd1, 1'b0})
                bad++;
        end
        start = 1'b0; spike_valid = 1'b0; spike_in = 8'h00;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL hold_stable got %0d unstable cycles want 0 (class=%0d count=%0d)",
                     bad, result_class, result_count);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_overrun got %0b want 1", overrun);
        end
        start = 1'b1; window_len = 8'd3; result_ready = 1'b1;
        tick();
        start = 1'b0; result_ready = 1'b0;
        checks++;
        if ({busy, result_valid, overrun} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL hold_release got busy=%0b valid=%0b ovr=%0b want 0/0/1",
                     busy, result_valid, overrun);
        end
    endtask

    task automatic test_reset_midcount();
        bit to;
        open_window(8'd5);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_clears_overrun got %0b want 0", overrun);
        end
        for (int s = 0; s < 2; s++) begin
            spike_valid = 1'b1; spike_in = 8'h0F;
            tick();
        end
        reset = 1'b1; start = 1'b1; window_len = 8'd2; spike_valid = 1'b1; result_ready = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; spike_valid = 1'b0; result_ready = 1'b0; spike_in = 8'h00;
        checks++;
        if ({busy, result_valid, result_class, result_count, result_tie, overrun} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL midcount_reset got busy=%0b valid=%0b class=%0d count=%0d tie=%0b ovr=%0b want 0",
                     busy, result_valid, result_class, result_count, result_tie, overrun);
        end
        open_window(8'd1);
        spike_valid = 1'b1; spike_in = 8'h80;
        tick();
        spike_valid = 1'b0; spike_in = 8'h00;
        wait_valid(to);
        checks++;
        if (to || {result_class, result_count, result_tie} !== {3'd7, 8'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL after_reset_result got timeout=%0b class=%0d count=%0d tie=%0b want 7/1/0",
                     to, result_class, result_count, result_tie);
        end
        release_result();
    endtask

    task automatic test_zero_len();
        int seen = 0;
        start = 1'b1; window_len = 8'd0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_len_busy got %0b want 0", busy);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (result_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL zero_len_result got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; window_len = 8'd0;
        spike_valid = 1'b0; spike_in = 8'h00; result_ready = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_all_zero();
        test_saturate();
        test_hold();
        test_reset_midcount();
        test_zero_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
